adder_share_arb: RTL
====================

# adder_share_arb

Round-robin arbiter and sequencer that shares one signed L-bit adder (a + b, two's-complement wrap-around) among N requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester per cycle, performs the addition, and holds the result in a single-entry output register with the requester ID and a signed-overflow flag. It sits between the arithmetic clients of the datapath and the shared adder resource.

## Interface
- L, default 4: operand and result width, signed two's complement.
- N, default 4: number of requesters, N ≥ 2.
- IDW, default $clog2(N): requester-ID width (derived; not overridden).

- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  N  bit i: requester i presents an operand pair.
- req_ready  out  N  bit i: requester i is granted this cycle; at most one bit set (one-hot or zero).
- req_a  in  N*L  operand a; requester i occupies bits [i*L +: L], signed.
- req_b  in  N*L  operand b; same packing as req_a, signed.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  L  signed sum, wrapped modulo 2^L.
- res_ovf  out  1  signed overflow of res_sum.
- res_id  out  IDW  index of the requester that produced res_sum.

## Operation
- State is the output register, which is either EMPTY (res_valid=0) or FULL (res_valid=1). A round-robin pointer ptr (IDW bits) holds the highest-priority index.
- can_accept = !res_valid | res_ready.
- Grant: when can_accept=1 and any req_valid bit is set, g is the first valid index found by searching ptr, ptr+1, … mod N.
  - req_ready[g]=1; all other ready bits are 0.
  - req_ready is combinational from req_valid, ptr and res_valid/res_ready.
  - When can_accept=0, req_ready=0.
- Transfer occurs when req_valid[g] & req_ready[g]. On the next edge:
  - res_sum ← a_g + b_g, truncated to L bits.
  - res_ovf ← (sign a_g == sign b_g) & (sign res_sum != sign a_g).
  - res_id ← g; res_valid ← 1.
  - ptr ← (g+1) mod N.
- Drain: res_valid & res_ready with no new transfer sets res_valid ← 0 (EMPTY). Drain and transfer in the same cycle reload the register, so res_valid stays 1.
- While FULL and res_ready=0, res_sum, res_ovf and res_id hold stable.
- Protocol rules for requesters:
  - Once req_valid[i] is asserted, req_a/req_b slice i stays stable and req_valid[i] stays high until accepted.
  - Withdrawing a request is illegal; behaviour is undefined.
- Fairness: a continuously valid requester is granted within N transfers.
- No grant occurs when no req_valid bit is set; ptr is unchanged.

## Timing
- Reset (rst_n=0 at an edge): res_valid=0, res_sum=0, res_ovf=0, res_id=0, ptr=0.
  - req_ready=0 during any cycle where rst_n=0, regardless of inputs.
  - Reset asserted mid-operation discards any held result. A request "granted" in the reset cycle is not transferred; the requester must keep it asserted.
- Latency: 1 cycle from transfer edge to res_valid/res_sum.
- Throughput: 1 result per cycle when res_ready=1 is held continuously.
- Backpressure: when FULL with res_ready=0, no grant is made. In the cycle res_ready rises, a grant is made in that same cycle (pass-through via can_accept).
- Wrap-around: ptr at N-1 advances to 0. Arithmetic wraps modulo 2^L with no saturation.
- Simultaneous requests: only one transfer per cycle; the others wait with req_ready=0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req_valid=4'b1111 → req_ready=0 and res_valid=0 throughout. After release, the first grant is req_ready=4'b0001 and the next cycle gives res_id=0.
- Single request, requester 2, a=3, b=2, res_ready=1 → req_ready=4'b0100 in the same cycle. Next cycle: res_valid=1, res_sum=5, res_ovf=0, res_id=2.
- Overflow, L=4:
  - 7+1 → res_sum=-8, res_ovf=1.
  - -8+(-1) → 7, res_ovf=1.
  - -3+(-4) → -7, res_ovf=0.
  - -5+5 → 0, res_ovf=0.
- Round-robin: all four requesters continuously valid, res_ready=1 → res_id sequence 0,1,2,3,0,1 on consecutive cycles, one transfer per cycle.
- Backpressure: result held with res_ready=0 for 3 cycles and req_valid=4'b0110 → outputs stable and req_ready=0. On the res_ready=1 cycle, req_ready=4'b0010 and the new result appears on the next cycle.
- Reset mid-operation: assert rst_n=0 while res_valid=1 with res_id=3 → next cycle res_valid=0, res_sum=0, res_id=0. After release, pending requests restart from ptr=0.

Source files
------------

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one signed L-bit adder among N
// requesters. The winning operand pair is added in the grant cycle and the
// sum, signed-overflow flag and requester ID land in a single-entry output
// register one cycle later. A new grant is only issued when that register
// is empty or being drained in the same cycle.
module adder_share_arb #(
   parameter  int L   = 4,
   parameter  int N   = 4,
   localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [N-1:0]     req_valid_i,
   output logic [N-1:0]     req_ready_o,
   input  logic [N*L-1:0]   req_a_i,
   input  logic [N*L-1:0]   req_b_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [L-1:0]     res_sum_o,
   output logic             res_ovf_o,
   output logic [IDW-1:0]   res_id_o
);

   // Unpacked per-requester operand views.
   logic [L-1:0]   op_a [N];
   logic [L-1:0]   op_b [N];

   // Round-robin pointer: index with the highest priority this cycle.
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;

   // Output register; res_valid_q doubles as the EMPTY/FULL state bit.
   logic           res_valid_q;
   logic           res_valid_d;
   logic [L-1:0]   res_sum_q;
   logic [L-1:0]   res_sum_d;
   logic           res_ovf_q;
   logic           res_ovf_d;
   logic [IDW-1:0] res_id_q;
   logic [IDW-1:0] res_id_d;

   // Arbitration and datapath nets.
   logic           can_accept;
   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   logic           xfer;
   logic [L-1:0]   sel_a;
   logic [L-1:0]   sel_b;
   logic [L-1:0]   add_sum;
   logic           add_ovf;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign op_a[gi] = req_a_i[gi*L +: L];
         assign op_b[gi] = req_b_i[gi*L +: L];
      end
   endgenerate

   // The register can take a new result when empty or being drained now.
   assign can_accept = !res_valid_q || res_ready_i;

   // Search ptr, ptr+1, ... (mod N) for the first valid requester.
   always_comb begin
      int            idx;
      logic [IDW-1:0] idx_w;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      idx_w       = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         idx_w = IDW'(idx);
         if (!grant_found && req_valid_i[idx_w]) begin
            grant_found = 1'b1;
            grant_idx   = idx_w;
         end
      end
   end

   // A grant is suppressed while in reset or while the register is blocked.
   assign xfer = grant_found && can_accept && rst_n_i;

   generate
      for (gi = 0; gi < N; gi++) begin : g_ready
         assign req_ready_o[gi] = xfer && (grant_idx == IDW'(gi));
      end
   endgenerate

   // Shared adder: wrap-around sum, overflow when like-signed operands
   // produce a result of the opposite sign.
   assign sel_a   = op_a[grant_idx];
   assign sel_b   = op_b[grant_idx];
   assign add_sum = sel_a + sel_b;
   assign add_ovf = (sel_a[L-1] == sel_b[L-1]) && (add_sum[L-1] != sel_a[L-1]);

   // Next state: load on transfer (even while draining), empty on a bare drain.
   always_comb begin
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_ovf_d   = res_ovf_q;
      res_id_d    = res_id_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         res_valid_d = 1'b1;
         res_sum_d   = add_sum;
         res_ovf_d   = add_ovf;
         res_id_d    = grant_idx;
         ptr_d       = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
      end else if (res_valid_q && res_ready_i) begin
         res_valid_d = 1'b0;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_ovf_q   <= 1'b0;
         res_id_q    <= '0;
         ptr_q       <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_ovf_q   <= res_ovf_d;
         res_id_q    <= res_id_d;
         ptr_q       <= ptr_d;
      end
   end

   // Outputs come straight from the register.
   always_comb begin
      res_valid_o = res_valid_q;
      res_sum_o   = res_sum_q;
      res_ovf_o   = res_ovf_q;
      res_id_o    = res_id_q;
   end

endmodule
